// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: raw rows in, column drive out, and the accepted key
// (rows/cols/key_valid) as seen by the downstream digit decoder.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;

    modport master (
        input  row_in,
        output col_drive,
        output rows,
        output cols,
        output key_valid
    );

    modport slave (
        output row_in,
        input  col_drive,
        input  rows,
        input  cols,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column drive, 2-flop row synchronizer,
// tick-paced press/release debounce and a one-shot key_valid per press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int unsigned   CW       = $clog2(SCAN_DIV);
    localparam int unsigned   SW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] TICK_AT  = CW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] stab_q;
    logic [3:0]    sync_q;
    logic [3:0]    rs_q;
    logic [3:0]    cand_row_q;
    logic [3:0]    cand_col_q;
    logic [3:0]    col_drive_q;
    logic [3:0]    rows_q;
    logic [3:0]    cols_q;
    logic          key_valid_q;

    logic          tick;
    logic [3:0]    rc;
    logic [3:0]    col_rot;
    logic [SW-1:0] stab_inc;
    logic          stab_done;

    assign tick      = (cnt_q == TICK_AT);
    // Two's-complement trick isolates the lowest set row bit.
    assign rc        = rs_q & (~rs_q + 4'd1);
    assign col_rot   = {col_drive_q[2:0], col_drive_q[3]};
    assign stab_inc  = stab_q + SW'(1);
    assign stab_done = (stab_inc == STAB_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            stab_q      <= '0;
            sync_q      <= '0;
            rs_q        <= '0;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            col_drive_q <= 4'b0001;
            rows_q      <= '0;
            cols_q      <= '0;
            key_valid_q <= 1'b0;
        end else begin
            sync_q      <= kp.row_in;
            rs_q        <= sync_q;
            cnt_q       <= tick ? '0 : cnt_q + CW'(1);
            key_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (rc != '0) begin
                            cand_row_q <= rc;
                            cand_col_q <= col_drive_q;
                            if (DEBOUNCE_CNT == 1) begin
                                rows_q      <= rc;
                                cols_q      <= col_drive_q;
                                key_valid_q <= 1'b1;
                                stab_q      <= '0;
                                state_q     <= HOLD;
                            end else begin
                                stab_q  <= SW'(1);
                                state_q <= DEBOUNCE;
                            end
                        end else begin
                            col_drive_q <= col_rot;
                        end
                    end
                    DEBOUNCE: begin
                        if (rc == cand_row_q) begin
                            if (stab_done) begin
                                rows_q      <= cand_row_q;
                                cols_q      <= cand_col_q;
                                key_valid_q <= 1'b1;
                                stab_q      <= '0;
                                state_q     <= HOLD;
                            end else begin
                                stab_q <= stab_inc;
                            end
                        end else begin
                            state_q     <= SCAN;
                            col_drive_q <= col_rot;
                            stab_q      <= '0;
                        end
                    end
                    HOLD: begin
                        // Any row activity in the held column restarts the release count.
                        if (rs_q == '0) begin
                            if (stab_done) begin
                                state_q     <= SCAN;
                                col_drive_q <= col_rot;
                                stab_q      <= '0;
                            end else begin
                                stab_q <= stab_inc;
                            end
                        end else begin
                            stab_q <= '0;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign kp.col_drive = col_drive_q;
    assign kp.rows      = rows_q;
    assign kp.cols      = cols_q;
    assign kp.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model answers the column
// drive, and a tick-level behavioural model predicts every output each cycle.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // keys[c] holds the rows pressed in column c; flip injects contact noise.
    logic [3:0] keys [4];
    logic [3:0] flip = '0;

    // Behavioural reference state.
    int         m_col, m_cnt, m_run, m_cand_r, m_cand_c;
    bit         m_locked;
    logic [3:0] m_r1, m_rs, m_rows, m_cols;
    logic       m_kv;

    int   pulses  = 0;
    logic prev_kv = 1'b0;
    int   budget;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept();
        m_rows   = 4'b0001 << m_cand_r;
        m_cols   = 4'b0001 << m_cand_c;
        m_kv     = 1'b1;
        m_locked = 1'b1;
        m_run    = 0;
    endtask

    task automatic model_tick(input logic [3:0] rs);
        int low;
        low = -1;
        for (int i = 3; i >= 0; i--) if (rs[i]) low = i;
        if (m_locked) begin
            if (rs == 4'b0) begin
                m_run++;
                if (m_run == DB) begin
                    m_locked = 1'b0;
                    m_run    = 0;
                    m_col    = (m_col + 1) % 4;
                end
            end else begin
                m_run = 0;
            end
        end else if (m_run == 0) begin
            if (low < 0) begin
                m_col = (m_col + 1) % 4;
            end else begin
                m_cand_r = low;
                m_cand_c = m_col;
                m_run    = 1;
                if (m_run == DB) accept();
            end
        end else if (low == m_cand_r) begin
            m_run++;
            if (m_run == DB) accept();
        end else begin
            m_run = 0;
            m_col = (m_col + 1) % 4;
        end
    endtask

    task automatic model_edge(input bit r, input logic [3:0] row_in);
        if (r) begin
            m_col = 0; m_cnt = 0; m_run = 0; m_locked = 1'b0;
            m_r1 = '0; m_rs = '0; m_rows = '0; m_cols = '0; m_kv = 1'b0;
        end else begin
            m_kv = 1'b0;
            if (m_cnt == SD - 1) model_tick(m_rs);
            m_cnt = (m_cnt + 1) % SD;
            m_rs  = m_r1;
            m_r1  = row_in;
        end
    endtask

    task automatic step(input bit r);
        logic [3:0] rin;
        rin         = keys[m_col] ^ flip;
        rst         = r;
        kif.row_in  = rin;
        @(posedge clk);
        model_edge(r, rin);
        #1;
        chk("col_drive", 32'(kif.col_drive), 32'(4'b0001 << m_col));
        chk("rows", 32'(kif.rows), 32'(m_rows));
        chk("cols", 32'(kif.cols), 32'(m_cols));
        chk("key_valid", 32'(kif.key_valid), 32'(m_kv));
        chk("kv_back_to_back", 32'(prev_kv & kif.key_valid), 32'd0);
        if (kif.key_valid === 1'b1) pulses++;
        prev_kv = kif.key_valid;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic clear_keys();
        for (int c = 0; c < 4; c++) keys[c] = 4'b0;
    endtask

    initial begin
        clear_keys();
        kif.row_in = '0;
        m_col = 0;

        // Reset and idle scan
        step(1'b1);
        chk("reset_col", 32'(kif.col_drive), 32'h1);
        chk("reset_rows", 32'(kif.rows), 32'h0);
        chk("reset_cols", 32'(kif.cols), 32'h0);
        chk("reset_kv", 32'(kif.key_valid), 32'h0);
        step(1'b1);
        step(1'b1);
        pulses = 0;
        run(20);
        chk("idle_pulses", 32'(pulses), 32'd0);

        // Clean press of (row1, col2)
        pulses  = 0;
        keys[2] = 4'b0010;
        run(60);
        chk("clean_pulses", 32'(pulses), 32'd1);
        chk("clean_rows", 32'(kif.rows), 32'h2);
        chk("clean_cols", 32'(kif.cols), 32'h4);

        // Release bouncing on alternate ticks keeps the column frozen
        for (int g = 0; g < 6; g++) begin
            keys[2] = (g % 2 == 0) ? 4'b0000 : 4'b0010;
            for (int k = 0; k < SD; k++) begin
                step(1'b0);
                chk("hold_frozen", 32'(kif.col_drive), 32'h4);
            end
        end
        keys[2] = 4'b0;
        budget  = 0;
        while (m_locked && budget < 40) begin step(1'b0); budget++; end
        chk("release_timeout", 32'(budget < 40), 32'd1);
        chk("release_resume", 32'(kif.col_drive), 32'h8);

        // Bounce during debounce: no pulse, scan moves on
        pulses  = 0;
        keys[2] = 4'b0010;
        budget  = 0;
        while (!(m_run == 1 && !m_locked) && budget < 60) begin step(1'b0); budget++; end
        chk("detect_timeout", 32'(budget < 60), 32'd1);
        keys[2] = 4'b0;
        run(SD);
        chk("bounce_col", 32'(kif.col_drive), 32'h8);
        chk("bounce_pulses", 32'(pulses), 32'd0);
        keys[2] = 4'b0010;
        run(60);
        chk("rebounce_pulses", 32'(pulses), 32'd1);
        keys[2] = 4'b0;
        run(40);

        // Two rows in column 0, then a key in another column while held
        pulses  = 0;
        keys[0] = 4'b1010;
        run(60);
        chk("multi_rows", 32'(kif.rows), 32'h2);
        chk("multi_cols", 32'(kif.cols), 32'h1);
        keys[3] = 4'b0001;
        run(40);
        chk("multi_pulses", 32'(pulses), 32'd1);
        clear_keys();
        run(60);

        // Reset on the edge before the committing tick
        pulses  = 0;
        keys[1] = 4'b0100;
        budget  = 0;
        while (!(!m_locked && m_run == DB - 1 && m_cnt == SD - 1) && budget < 80) begin
            step(1'b0);
            budget++;
        end
        chk("predeb_timeout", 32'(budget < 80), 32'd1);
        clear_keys();
        step(1'b1);
        chk("midrst_col", 32'(kif.col_drive), 32'h1);
        chk("midrst_rows", 32'(kif.rows), 32'h0);
        chk("midrst_cols", 32'(kif.cols), 32'h0);
        chk("midrst_kv", 32'(kif.key_valid), 32'h0);
        run(30);
        chk("midrst_pulses", 32'(pulses), 32'd0);

        // Random presses with contact noise
        for (int it = 0; it < 16; it++) begin
            int         c;
            int         hold_n;
            int         rel_n;
            c       = int'($urandom_range(0, 3));
            hold_n  = int'($urandom_range(30, 70));
            rel_n   = int'($urandom_range(30, 60));
            keys[c] = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) keys[(c + 1) % 4] = 4'($urandom_range(1, 15));
            for (int k = 0; k < hold_n; k++) begin
                flip = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
                step(1'b0);
            end
            clear_keys();
            for (int k = 0; k < rel_n; k++) begin
                flip = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
                step(1'b0);
            end
        end
        flip = '0;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
